// File: rtl/spi_slave_out.sv
// SPI mode-0 transmit-only slave: synchronizes sck/cs into the clk domain and
// shifts a BITS-wide word out on miso, MSB first, with done/abort end pulses.
module spi_slave_out #(
    parameter int BITS = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [BITS-1:0] in_buf,
    input  logic            sck,
    input  logic            cs,
    output logic            miso,
    output logic            miso_oe,
    output logic            busy,
    output logic            done,
    output logic            abort
);

    localparam int CW = $clog2(BITS + 1);
    localparam logic [CW-1:0] RCNT_FULL = CW'(BITS);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t state_reg, state_next;

    logic sck_meta_reg, sck_sync_reg, sck_last_reg;
    logic cs_meta_reg, cs_sync_reg, cs_last_reg;

    logic [1:0] prime_reg;
    logic       armed_reg;

    logic [BITS-1:0] shreg_reg, shreg_next;
    logic [CW-1:0]   rcnt_reg, rcnt_next;
    logic            miso_reg, miso_next;
    logic            oe_reg, oe_next;
    logic            busy_reg, busy_next;
    logic            done_reg, done_next;
    logic            abort_reg, abort_next;

    logic sck_rise, sck_fall, cs_rise, cs_fall, start;

    // Two-flop synchronizers plus a last-value stage for edge detection.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sck_meta_reg <= 1'b0;
            sck_sync_reg <= 1'b0;
            sck_last_reg <= 1'b0;
            cs_meta_reg  <= 1'b1;
            cs_sync_reg  <= 1'b1;
            cs_last_reg  <= 1'b1;
        end else begin
            sck_meta_reg <= sck;
            sck_sync_reg <= sck_meta_reg;
            sck_last_reg <= sck_sync_reg;
            cs_meta_reg  <= cs;
            cs_sync_reg  <= cs_meta_reg;
            cs_last_reg  <= cs_sync_reg;
        end
    end

    assign sck_rise = sck_sync_reg & ~sck_last_reg;
    assign sck_fall = ~sck_sync_reg & sck_last_reg;
    assign cs_rise  = cs_sync_reg & ~cs_last_reg;
    assign cs_fall  = ~cs_sync_reg & cs_last_reg;

    // The cs chain resets high, so a pin already low at reset release would look
    // like a falling edge. Only arm once the synchronized cs has really been seen high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prime_reg <= 2'd0;
            armed_reg <= 1'b0;
        end else begin
            if (prime_reg != 2'd2)
                prime_reg <= prime_reg + 2'd1;
            if (prime_reg == 2'd2 && cs_sync_reg)
                armed_reg <= 1'b1;
        end
    end

    assign start = cs_fall & armed_reg;

    always_ff @(posedge clk) begin
        if (!reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start)   state_next = SHIFT;
            SHIFT:   if (cs_rise) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        shreg_next = shreg_reg;
        rcnt_next  = rcnt_reg;
        miso_next  = miso_reg;
        oe_next    = oe_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        abort_next = 1'b0;
        case (state_reg)
            IDLE: begin
                miso_next = 1'b0;
                oe_next   = 1'b0;
                busy_next = 1'b0;
                if (start) begin
                    shreg_next = in_buf;
                    miso_next  = in_buf[BITS-1];
                    rcnt_next  = '0;
                    oe_next    = 1'b1;
                    busy_next  = 1'b1;
                end
            end
            SHIFT: begin
                // cs rising takes priority; any simultaneous sck edge is dropped.
                if (cs_rise) begin
                    done_next  = (rcnt_reg == RCNT_FULL);
                    abort_next = (rcnt_reg != RCNT_FULL);
                    miso_next  = 1'b0;
                    oe_next    = 1'b0;
                    busy_next  = 1'b0;
                end else begin
                    if (sck_rise && rcnt_reg != RCNT_FULL)
                        rcnt_next = rcnt_reg + 1'b1;
                    if (sck_fall) begin
                        if (rcnt_reg < RCNT_FULL) begin
                            shreg_next = {shreg_reg[BITS-2:0], 1'b0};
                            miso_next  = shreg_reg[BITS-2];
                        end else begin
                            miso_next = 1'b0;
                        end
                    end
                end
            end
            default: begin
                miso_next = 1'b0;
                oe_next   = 1'b0;
                busy_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            shreg_reg <= '0;
            rcnt_reg  <= '0;
            miso_reg  <= 1'b0;
            oe_reg    <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            abort_reg <= 1'b0;
        end else begin
            shreg_reg <= shreg_next;
            rcnt_reg  <= rcnt_next;
            miso_reg  <= miso_next;
            oe_reg    <= oe_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            abort_reg <= abort_next;
        end
    end

    assign miso    = miso_reg;
    assign miso_oe = oe_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;
    assign abort   = abort_reg;

endmodule
